// File: rtl/ahb_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_apb_pkg
// Description : Shared AHB transfer/response encodings and bridge FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1
    } hresp_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } bridge_state_t;

    // Slave index width, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_mux.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_mux
// Description : Selects read data, ready and error of the addressed APB slave.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_mux
    import ahb_apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int IDX_W      = 2
) (
    input  logic [IDX_W-1:0]                 idx_i,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] p_rdata_i,
    input  logic [NUM_SLAVES-1:0]            p_ready_i,
    input  logic [NUM_SLAVES-1:0]            p_slverr_i,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             ready_o,
    output logic                             slverr_o
);

    // Out-of-range indices select nothing, so all outputs stay low.
    always_comb begin
        rdata_o  = '0;
        ready_o  = 1'b0;
        slverr_o = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_i == IDX_W'(i)) begin
                rdata_o  = p_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                ready_o  = p_ready_i[i];
                slverr_o = p_slverr_i[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_apb_bridge_multi.sv
`default_nettype none
// ============================================================================
// Module      : ahb_apb_bridge_multi
// Description : AHB-to-APB bridge with address-decoded multi-slave APB port.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_apb_bridge_multi
    import ahb_apb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_SLAVES  = 4,
    parameter int SLV_SEL_LSB = 12,
    parameter int TIMEOUT     = 16
) (
    input  logic                             H_CLK,
    input  logic                             H_RESET,
    input  logic                             H_SEL,
    input  logic                             H_READY_IN,
    input  logic [1:0]                       H_TRANS,
    input  logic                             H_WRITE,
    input  logic [ADDR_WIDTH-1:0]            H_ADDR,
    input  logic [DATA_WIDTH-1:0]            H_WDATA,
    output logic                             H_READY_OUT,
    output logic [1:0]                       H_RESP,
    output logic [DATA_WIDTH-1:0]            H_RDATA,
    output logic [NUM_SLAVES-1:0]            P_SEL,
    output logic                             P_ENABLE,
    output logic                             P_WRITE,
    output logic [ADDR_WIDTH-1:0]            P_ADDR,
    output logic [DATA_WIDTH-1:0]            P_WDATA,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] P_RDATA,
    input  logic [NUM_SLAVES-1:0]            P_READY,
    input  logic [NUM_SLAVES-1:0]            P_SLVERR
);

    localparam int IDX_W = idx_width(NUM_SLAVES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    bridge_state_t          state_q;
    bridge_state_t          state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   write_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    logic [IDX_W-1:0]       w_idx;
    logic [IDX_W-1:0]       w_in_idx;
    logic                   w_in_valid;
    logic                   w_capture;
    logic                   w_apb_active;
    logic                   w_err;
    logic [DATA_WIDTH-1:0]  w_sel_rdata;
    logic                   w_sel_ready;
    logic                   w_sel_slverr;

    assign w_idx      = addr_q[SLV_SEL_LSB +: IDX_W];
    assign w_in_idx   = H_ADDR[SLV_SEL_LSB +: IDX_W];
    assign w_in_valid = (32'(w_in_idx) < 32'(NUM_SLAVES));

    // ERR2 drives H_READY_OUT high but must not accept a new transfer.
    assign w_capture = ((state_q == ST_IDLE) || (state_q == ST_DONE))
                     & H_SEL & H_READY_IN & H_READY_OUT
                     & ((H_TRANS == HTRANS_NONSEQ) || (H_TRANS == HTRANS_SEQ));

    apb_slave_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W)
    ) u_slave_mux (
        .idx_i      (w_idx),
        .p_rdata_i  (P_RDATA),
        .p_ready_i  (P_READY),
        .p_slverr_i (P_SLVERR),
        .rdata_o    (w_sel_rdata),
        .ready_o    (w_sel_ready),
        .slverr_o   (w_sel_slverr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (!w_capture) begin
                    state_d = ST_IDLE;
                end else if (!w_in_valid) begin
                    state_d = ST_ERR1;
                end else if (H_WRITE) begin
                    state_d = ST_WDATA;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_WDATA:  state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                // cnt_q holds the number of ACCESS cycles already spent waiting.
                if (w_sel_ready) begin
                    if (w_sel_slverr) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ERR1:   state_d = ST_ERR2;
            ST_ERR2:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge H_CLK) begin
        if (H_RESET) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_capture) begin
                addr_q  <= H_ADDR;
                write_q <= H_WRITE;
            end
            if (state_q == ST_WDATA) begin
                wdata_q <= H_WDATA;
            end
            if ((state_q == ST_ACCESS) && !write_q && w_sel_ready && !w_sel_slverr) begin
                rdata_q <= w_sel_rdata;
            end
        end
    end

    assign w_apb_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign w_err        = (state_q == ST_ERR1) || (state_q == ST_ERR2);

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_psel
        assign P_SEL[gi] = w_apb_active && (w_idx == IDX_W'(gi));
    end

    assign P_ENABLE    = (state_q == ST_ACCESS);
    assign P_WRITE     = write_q;
    assign P_ADDR      = addr_q;
    assign P_WDATA     = wdata_q;
    assign H_RDATA     = rdata_q;
    assign H_READY_OUT = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
    assign H_RESP      = w_err ? HRESP_ERROR : HRESP_OKAY;

endmodule
`default_nettype wire

// File: doc/ahb_apb_bridge_multi.md
AHB_APB_BRIDGE_MULTI -- requirements
Module: ahb_apb_bridge_multi

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AHB/APB data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AHB/APB address width.
REQ-003 SHALL have parameter NUM_SLAVES, default 4, number of APB slaves (1..16).
REQ-004 SHALL have parameter SLV_SEL_LSB, default 12, lowest H_ADDR bit of slave index; IDX_W = max(1, clog2(NUM_SLAVES)).
REQ-005 SHALL have parameter TIMEOUT, default 16, max ACCESS cycles without P_READY.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have ports:
- H_CLK  in  1  clock, all logic on rising edge
- H_RESET  in  1  synchronous active-high reset
- H_SEL  in  1  bridge selected
- H_READY_IN  in  1  AHB bus ready
- H_TRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- H_WRITE  in  1  1=write
- H_ADDR  in  ADDR_WIDTH  transfer address
- H_WDATA  in  DATA_WIDTH  write data (data phase)
- H_READY_OUT  out  1  bridge ready
- H_RESP  out  2  OKAY=0, ERROR=1
- H_RDATA  out  DATA_WIDTH  read data
- P_SEL  out  NUM_SLAVES  one-hot slave select
- P_ENABLE  out  1  APB access phase
- P_WRITE  out  1  APB direction
- P_ADDR  out  ADDR_WIDTH  APB address
- P_WDATA  out  DATA_WIDTH  APB write data
- P_RDATA  in  NUM_SLAVES*DATA_WIDTH  packed slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- P_READY  in  NUM_SLAVES  per-slave ready
- P_SLVERR  in  NUM_SLAVES  per-slave error

Function
REQ-008 SHALL capture a transfer when H_SEL & H_READY_IN & H_READY_OUT & H_TRANS in {NONSEQ, SEQ}; IDLE/BUSY get zero-wait OKAY, no APB activity.
REQ-009 SHALL register H_ADDR and H_WRITE at capture, and compute idx = H_ADDR[SLV_SEL_LSB +: IDX_W].
REQ-010 SHALL use states IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2.
REQ-011 IDLE/DONE on capture: idx >= NUM_SLAVES -> ERR1; write -> WDATA; read -> SETUP; else IDLE.
REQ-012 WDATA SHALL latch H_WDATA into P_WDATA, then go to SETUP.
REQ-013 SETUP SHALL assert P_SEL[idx], P_ENABLE=0, then go to ACCESS.
REQ-014 ACCESS SHALL hold P_SEL[idx] with P_ENABLE=1 and the same address, direction and data.
REQ-015 ACCESS exit: P_READY[idx]&!P_SLVERR[idx] -> DONE; P_READY[idx]&P_SLVERR[idx] -> ERR1; TIMEOUT cycles without P_READY[idx] -> ERR1.
REQ-016 Any ACCESS exit SHALL deassert P_SEL and P_ENABLE.
REQ-017 A read completing in ACCESS SHALL register P_RDATA of slave idx into H_RDATA; H_RDATA holds otherwise.
REQ-018 H_READY_OUT SHALL be 0 in WDATA, SETUP, ACCESS and ERR1, and 1 in IDLE, DONE and ERR2.
REQ-019 H_RESP SHALL be ERROR in ERR1 and ERR2 and OKAY elsewhere; ERR1 -> ERR2 -> IDLE unconditionally.
REQ-020 Read latency SHALL be capture edge + 3 cycles to H_READY_OUT=1 with zero-wait slave; write SHALL be +4.
REQ-021 DONE SHALL accept a new capture (back-to-back pipelining); ERR2 SHALL not capture.
REQ-022 P_READY/P_SLVERR of unselected slaves SHALL be ignored; at most one P_SEL bit is high.

Reset
REQ-023 H_RESET SHALL force, at the next edge, state=IDLE and P_SEL=0, P_ENABLE=0, P_WRITE=0, P_ADDR=0, P_WDATA=0, H_RDATA=0, H_READY_OUT=1, H_RESP=OKAY, timeout counter=0.
REQ-024 Reset mid-transfer SHALL abandon the transfer with no completion or error response.

Structure
REQ-025 Package ahb_apb_pkg SHALL hold the htrans_t, hresp_t and bridge state enums.
REQ-026 Sub-module apb_slave_mux SHALL select P_RDATA/P_READY/P_SLVERR by idx (combinational); the FSM, counter and registers SHALL stay in ahb_apb_bridge_multi.

Verification
REQ-027 Read NONSEQ, H_ADDR=0x0000_1004, slave1 P_READY=1, P_RDATA=0xDEADBEEF -> P_SEL=0010, H_READY_OUT=1 three cycles later, H_RDATA=0xDEADBEEF, H_RESP=OKAY.
REQ-028 Write H_ADDR=0x0000_2008, H_WDATA=0x12345678, slave2 P_READY low 3 cycles -> P_WDATA=0x12345678 stable through SETUP/ACCESS, 3 extra wait states, OKAY.
REQ-029 Read to slave0 with P_SLVERR=1 at P_READY -> H_RESP=ERROR two cycles, H_READY_OUT 0 then 1.
REQ-030 NUM_SLAVES=3, H_ADDR=0x0000_3000 -> no P_SEL, ERR1/ERR2 response; slave0 never answering -> ERROR after exactly 16 ACCESS cycles.
REQ-031 Back-to-back NONSEQ/SEQ reads 0x0, 0x4, 0x8 -> three APB transfers, each capture in DONE; H_RESET in ACCESS -> next cycle all P_SEL=0, H_READY_OUT=1.
